// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and defaults for the data-memory bridge.
//   dmem_state_t  - bridge FSM state (IDLE, REQ, RSP, DONE)
//   DMEM_*        - default address width, data width and timeout
//   word_aligned  - true when a byte address is word aligned
package dmem_bridge_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} dmem_state_t;

    localparam int DMEM_AW      = 32;
    localparam int DMEM_DW      = 32;
    localparam int DMEM_TIMEOUT = 255;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: cycle counter that flags the last allowed cycle of a
// bus transaction.
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-low
//   clear   in  restart the count at zero
//   enable  in  count this cycle
//   hit     out this is the TIMEOUT-th enabled cycle since clear
module dmem_timeout_ctr
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted on the cycle whose increment would reach TIMEOUT, so the
    // owner leaves REQ/RSP exactly TIMEOUT cycles after entering REQ.
    assign hit = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle core loads/stores into handshaked bus
// request/response transactions, stalling the core until completion and
// flagging misaligned, errored and timed-out accesses.
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   core_memwrite/core_memread store/load request levels, held while stalled
//   core_addr, core_wdata      byte address and store data from the core
//   core_rdata, core_stall     load data (valid in DONE) and stall to the core
//   bus_req_*                  request channel (valid/ready/we/addr/wdata)
//   bus_rsp_*                  response channel (valid/rdata/err)
//   err, err_addr              sticky error flag and first failing address
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int AW      = DMEM_AW,
    parameter int DW      = DMEM_DW,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_memwrite,
    input  logic          core_memread,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    output logic          bus_req_valid,
    input  logic          bus_req_ready,
    output logic          bus_req_we,
    output logic [AW-1:0] bus_req_addr,
    output logic [DW-1:0] bus_req_wdata,
    input  logic          bus_rsp_valid,
    input  logic [DW-1:0] bus_rsp_rdata,
    input  logic          bus_rsp_err,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    dmem_state_t   state;
    logic [AW-1:0] addr_q;
    logic          access;
    logic          aligned;
    logic          accept;
    logic          to_clear;
    logic          to_enable;
    logic          to_hit;
    logic          err_event;
    logic [AW-1:0] err_src;

    assign access    = core_memread | core_memwrite;
    assign aligned   = word_aligned(core_addr[1:0]);
    assign accept    = bus_req_valid & bus_req_ready;
    assign to_clear  = (state == IDLE) & access & aligned;
    assign to_enable = (state == REQ) | (state == RSP);

    assign core_stall   = (state == IDLE) ? access : (state != DONE);
    assign bus_req_addr = {addr_q[AW-1:2], 2'b00};

    // Every error path ends the access in DONE; the response, when present,
    // takes precedence over a coincident timeout in RSP.
    always_comb begin
        err_event = 1'b0;
        unique case (state)
            IDLE:    err_event = access & ~aligned;
            REQ:     err_event = to_hit;
            RSP:     err_event = bus_rsp_valid ? bus_rsp_err : to_hit;
            default: err_event = 1'b0;
        endcase
    end

    assign err_src = (state == IDLE) ? core_addr : addr_q;

    dmem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (to_clear),
        .enable(to_enable),
        .hit   (to_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_wdata <= '0;
            core_rdata    <= '0;
            err           <= 1'b0;
            err_addr      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        addr_q        <= core_addr;
                        bus_req_wdata <= core_wdata;
                        bus_req_we    <= core_memwrite;
                        if (!aligned) begin
                            core_rdata <= '0;
                            state      <= DONE;
                        end else begin
                            bus_req_valid <= 1'b1;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (to_hit) begin
                        bus_req_valid <= 1'b0;
                        core_rdata    <= '0;
                        state         <= DONE;
                    end else if (accept) begin
                        bus_req_valid <= 1'b0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (bus_rsp_valid) begin
                        core_rdata <= (bus_req_we | bus_rsp_err) ? '0 : bus_rsp_rdata;
                        state      <= DONE;
                    end else if (to_hit) begin
                        core_rdata <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (err_event) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= err_src;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed bench for dmem_bridge with a transaction-level
// reference model (expected data, latency, sticky error) and a per-cycle
// compare process, plus literal expectations for the directed cases.
module tb_dmem_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_memwrite, core_memread;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;
    logic        err;
    logic [31:0] err_addr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_mis, m_fault;
    logic [31:0] m_exp_rdata, m_addr;
    int          m_exp_stalls;
    bit          m_err;
    logic [31:0] m_err_addr;

    // Results recorded by the access driver
    logic [31:0] last_rdata;
    int          last_stalls;

    always #5 clk = ~clk;

    dmem_bridge #(
        .AW(32),
        .DW(32),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_memwrite(core_memwrite),
        .core_memread (core_memread),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .core_stall   (core_stall),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_we   (bus_req_we),
        .bus_req_addr (bus_req_addr),
        .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err  (bus_rsp_err),
        .err          (err),
        .err_addr     (err_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus_req_valid) begin
                chk("req_addr", bus_req_addr, {core_addr[31:2], 2'b00});
                chk("req_we", 32'(bus_req_we), 32'(core_memwrite));
                chk("req_wdata", bus_req_wdata, core_wdata);
                chk("stall_in_req", 32'(core_stall), 32'd1);
            end
            if (!(core_memread | core_memwrite)) begin
                chk("stall_idle", 32'(core_stall), 32'd0);
            end else if (!core_stall) begin
                if (m_fault && !m_err) begin
                    m_err      = 1'b1;
                    m_err_addr = m_addr;
                end
                chk("done_rdata", core_rdata, m_exp_rdata);
            end
            chk("err", 32'(err), 32'(m_err));
            chk("err_addr", err_addr, m_err_addr);
        end
    end

    // One core access plus the bus responder for it. Inputs change #1 after
    // the rising edge; returns one cycle after DONE with the request dropped.
    task automatic do_access(input bit wr, input bit both, input logic [31:0] a,
                             input logic [31:0] wd, input int rwait, input int rspw,
                             input bit respond, input logic [31:0] rd, input bit rerr);
        int  req_cycles = 0;
        int  accepts    = 0;
        int  since      = 0;
        int  stalls     = 0;
        bit  acc_seen   = 0;
        bit  done       = 0;
        m_mis        = (a[1:0] != 2'b00);
        m_fault      = m_mis || !respond || rerr;
        m_exp_rdata  = (m_fault || wr) ? 32'h0 : rd;
        m_exp_stalls = m_mis ? 1 : (!respond ? 1 + TO : 1 + (rwait + 1) + rspw);
        m_addr       = a;
        @(posedge clk); #1;
        core_memwrite = wr;
        core_memread  = !wr || both;
        core_addr     = a;
        core_wdata    = wd;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            bus_req_ready = bus_req_valid && (req_cycles >= rwait);
            if (bus_req_valid) req_cycles++;
            if (acc_seen) since++;
            bus_rsp_valid = respond && acc_seen && (since == rspw);
            bus_rsp_rdata = bus_rsp_valid ? rd : 32'hA5A5_A5A5;
            bus_rsp_err   = bus_rsp_valid ? rerr : 1'b1;
            if (bus_req_valid && bus_req_ready) begin
                accepts++;
                acc_seen = 1;
                since    = 0;
            end
            #1;
            if (core_stall) begin
                stalls++;
            end else begin
                done       = 1;
                last_rdata = core_rdata;
            end
            @(posedge clk); #1;
        end
        core_memwrite = 0;
        core_memread  = 0;
        bus_req_ready = 0;
        bus_rsp_valid = 0;
        bus_rsp_err   = 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_done actual=no_done required=done addr=%h", a);
        end
        last_stalls = stalls;
        chk("stall_cycles", 32'(stalls), 32'(m_exp_stalls));
        chk("accepts", 32'(accepts), m_mis ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0;
        core_memwrite = 0; core_memread = 0; core_addr = '0; core_wdata = '0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = '0; bus_rsp_err = 0;
        m_err = 0; m_err_addr = '0; m_fault = 0; m_mis = 0; m_exp_rdata = '0; m_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_addr", bus_req_addr, 32'h0);
        reset = 1;

        // Minimum-latency load
        do_access(0, 0, 32'h100, 32'h0, 0, 1, 1, 32'hDEADBEEF, 0);
        chk("lit_load_rdata", last_rdata, 32'hDEADBEEF);
        chk("lit_load_stalls", 32'(last_stalls), 32'd3);
        chk("lit_load_err", 32'(err), 32'd0);

        // Store with ready held low 4 cycles; response data must not leak
        do_access(1, 0, 32'h204, 32'h12345678, 4, 2, 1, 32'hFFFFFFFF, 0);
        chk("lit_store_rdata", last_rdata, 32'h0);
        chk("lit_store_stalls", 32'(last_stalls), 32'd8);

        // Misaligned load
        do_access(0, 0, 32'h103, 32'h0, 0, 1, 1, 32'h11112222, 0);
        chk("lit_mis_stalls", 32'(last_stalls), 32'd1);
        chk("lit_mis_rdata", last_rdata, 32'h0);
        chk("lit_mis_err", 32'(err), 32'd1);
        chk("lit_mis_err_addr", err_addr, 32'h103);

        // Accepted read that never gets a response
        do_access(0, 0, 32'h108, 32'h0, 0, 1, 0, 32'h0, 0);
        chk("lit_to_stalls", 32'(last_stalls), 32'd9);
        chk("lit_to_rdata", last_rdata, 32'h0);
        bus_rsp_valid = 1; bus_rsp_rdata = 32'h55; bus_rsp_err = 0;
        @(posedge clk); #1;
        bus_rsp_valid = 0;
        #1;
        chk("stray_rdata", core_rdata, 32'h0);
        chk("stray_valid", 32'(bus_req_valid), 32'd0);
        chk("stray_err_addr", err_addr, 32'h103);

        // Reset while waiting in RSP, followed by a late errored response
        @(posedge clk); #1;
        core_memread = 1; core_addr = 32'h300; core_wdata = 32'h0;
        @(posedge clk); #1;
        chk("abort_in_req", 32'(bus_req_valid), 32'd1);
        bus_req_ready = 1;
        @(posedge clk); #1;
        bus_req_ready = 0;
        chk("abort_in_rsp", 32'(bus_req_valid), 32'd0);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        core_memread = 0;
        m_err = 0; m_err_addr = '0; m_fault = 0;
        bus_rsp_valid = 1; bus_rsp_rdata = 32'h77; bus_rsp_err = 1;
        #1;
        chk("abort_stall", 32'(core_stall), 32'd0);
        chk("abort_valid", 32'(bus_req_valid), 32'd0);
        chk("abort_rdata", core_rdata, 32'h0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_addr", bus_req_addr, 32'h0);
        @(posedge clk); #1;
        bus_rsp_valid = 0; bus_rsp_err = 0;
        #1;
        chk("late_rsp_err", 32'(err), 32'd0);
        chk("late_rsp_rdata", core_rdata, 32'h0);

        // Next access after the abort completes normally
        do_access(0, 0, 32'h300, 32'h0, 1, 3, 1, 32'hCAFEF00D, 0);
        chk("lit_post_rdata", last_rdata, 32'hCAFEF00D);
        chk("lit_post_stalls", 32'(last_stalls), 32'd6);

        // Two bus errors: the first address is the one kept
        do_access(0, 0, 32'h40, 32'h0, 0, 1, 1, 32'h11111111, 1);
        chk("lit_berr_rdata", last_rdata, 32'h0);
        do_access(1, 0, 32'h80, 32'hABCD, 2, 1, 1, 32'h0, 1);
        chk("lit_berr_err", 32'(err), 32'd1);
        chk("lit_berr_err_addr", err_addr, 32'h40);

        // Read and write both requested: write wins
        do_access(1, 1, 32'h84, 32'h5A5A5A5A, 0, 1, 1, 32'h99999999, 0);
        chk("lit_both_rdata", last_rdata, 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
